pmod_hash_sequencer: RTL and testbench
======================================

PMOD_HASH_SEQUENCER -- requirements
Module: pmod_hash_sequencer

Interface
REQ-001 Parameters SHALL be:
- CONF_N, default 4: config bytes per job {kk, nn, ll[7:0], ll[15:8]}.
- BLOCK_N, default 64: bytes per BLAKE2 block.
- TIMEOUT, default 4096: maximum WAIT_HASH cycles.
REQ-002 Ports SHALL be:
- clk_io_bus, in, 1: Pmod I/O bank clock.
- rst_async, in, 1: asynchronous reset, active-high.
- start_i, in, 1: job request; accepted only in IDLE.
- key_len_i, in, 6: kk, 0..32.
- hash_len_i, in, 6: nn, 1..32.
- msg_len_i, in, 16: message bytes ll.
- src_valid_i, in, 1: host byte valid.
- src_data_i, in, 8: host byte (key block bytes first if kk>0, then message).
- src_ready_o, out, 1: host byte accepted when src_valid_i & src_ready_o.
- data_o, out, 8: Pmod A byte to ASIC.
- data_ctrl_o, out, 3: Pmod B; [0]=valid, [2:1]=type (00 conf, 01 data, 10 final-block data, 11 reserved, never driven).
- hash_i, in, 8: Pmod D hash byte.
- hash_ctrl_i, in, 2: [0]=ASIC ready for data, [1]=hash byte valid.
- res_valid_o, out, 1: result byte strobe, no backpressure.
- res_data_o, out, 8: result byte.
- res_last_o, out, 1: final result byte.
- busy_o, out, 1: state != IDLE.
- error_o, out, 1: sticky error flag.

Function
REQ-003 FSM states SHALL be IDLE, CONF, DATA, PAD, WAIT_HASH, READ; all outputs SHALL be registered.
REQ-004 IDLE→CONF on start_i; job parameters SHALL be latched that cycle; start_i outside IDLE SHALL be ignored.
REQ-005 A Pmod byte SHALL transfer on a cycle where data_ctrl_o[0] and hash_ctrl_i[0] are both high; data_o/data_ctrl_o SHALL hold stable until then.
REQ-006 CONF SHALL emit CONF_N bytes with type 00, then go to DATA.
REQ-007 Payload length SHALL be P = (kk>0 ? BLOCK_N : 0) + ll; key bytes beyond kk within the key block SHALL be sent as 0x00, without consuming src.
REQ-008 Block count SHALL be B = max(1, ceil(P/BLOCK_N)), computed with 17-bit arithmetic; the bytes of block B SHALL carry type 10, all others type 01.
REQ-009 DATA SHALL pull one src byte per Pmod transfer; src_ready_o SHALL be high only when the output register is empty or is transferring that cycle (one-byte skid, no bubble at full rate).
REQ-010 After P payload bytes, if the byte count mod BLOCK_N != 0 or P==0, the FSM SHALL enter PAD and emit 0x00 type-10 bytes up to the block boundary; otherwise it SHALL go to WAIT_HASH.
REQ-011 WAIT_HASH SHALL go to READ on the first hash_ctrl_i[1] high; that byte SHALL be counted as result byte 0.
REQ-012 In READ, each hash_ctrl_i[1] cycle SHALL produce res_valid_o one cycle later with res_data_o=hash_i; res_last_o SHALL mark byte nn-1, then the FSM SHALL return to IDLE.
REQ-013 A WAIT_HASH timeout counter SHALL count cycles; reaching TIMEOUT SHALL set error_o and return to IDLE.
REQ-014 In READ, a gap of more than TIMEOUT cycles between hash bytes SHALL likewise set error_o and return to IDLE.
REQ-015 A job with kk>32, nn==0 or nn>32 SHALL set error_o in CONF without emitting any byte and return to IDLE.
REQ-016 hash_ctrl_i[1] in any state other than WAIT_HASH/READ SHALL set error_o and be otherwise ignored.
REQ-017 error_o SHALL clear only on reset or on the next accepted start_i.

Reset
REQ-018 While rst_async is high: state=IDLE, data_o=0, data_ctrl_o=0, src_ready_o=0, res_valid_o=0, res_data_o=0, res_last_o=0, busy_o=0, error_o=0, all counters 0.
REQ-019 Reset asserted mid-job SHALL abort the job immediately with no further Pmod valid.
REQ-020 Reset release SHALL be synchronised to clk_io_bus with a 2-flop synchroniser.

Verification
REQ-021 Unkeyed job: kk=0, nn=32, ll=3, ready always high → 4 conf bytes {00,20,03,00}, 3 data bytes type 10, then 61 zero bytes type 10; ASIC returns 32 hash bytes → 32 res_valid_o, res_last_o on byte 31.
REQ-022 Keyed job: kk=16, ll=64 → 16 key bytes from src, 48 zero pad bytes type 01, 64 message bytes type 10, B=2.
REQ-023 Empty message: ll=0, kk=0 → exactly 64 0x00 type-10 bytes.
REQ-024 Backpressure: toggle hash_ctrl_i[0] randomly → data_o stable while not accepted, no byte lost or duplicated; byte sequence matches reference.
REQ-025 Timeout: no hash_ctrl_i[1] for 4096 cycles → error_o=1, busy_o=0; next start_i clears error_o.
REQ-026 Reset mid-DATA at byte 20 → all outputs zero same cycle; new job afterwards completes normally.

Source files
------------

// File: rtl/pmod_hash_sequencer.sv
// Pmod bridge that streams BLAKE2 jobs (config, key block, message, padding)
// to an external hash ASIC and returns the digest bytes it sends back.
module pmod_hash_sequencer #(
    parameter int CONF_N  = 4,
    parameter int BLOCK_N = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk_io_bus,
    input  logic        rst_async,
    input  logic        start_i,
    input  logic [5:0]  key_len_i,
    input  logic [5:0]  hash_len_i,
    input  logic [15:0] msg_len_i,
    input  logic        src_valid_i,
    input  logic [7:0]  src_data_i,
    output logic        src_ready_o,
    output logic [7:0]  data_o,
    output logic [2:0]  data_ctrl_o,
    input  logic [7:0]  hash_i,
    input  logic [1:0]  hash_ctrl_i,
    output logic        res_valid_o,
    output logic [7:0]  res_data_o,
    output logic        res_last_o,
    output logic        busy_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONF, S_DATA, S_PAD, S_WAIT, S_READ
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] BLK = 17'(BLOCK_N);
    localparam logic [16:0] CFN = 17'(CONF_N);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // reset asserts immediately, releases two clock edges later
    logic [1:0] rsync_q, rsync_d;
    logic       rst;
    assign rsync_d = {rsync_q[0], 1'b0};
    assign rst     = rsync_q[1];

    always_ff @(posedge clk_io_bus or posedge rst_async) begin
        if (rst_async) rsync_q <= 2'b11;
        else           rsync_q <= rsync_d;
    end

    state_t        state_q, state_d;
    logic [5:0]    kk_q, kk_d, nn_q, nn_d, rcnt_q, rcnt_d;
    logic [15:0]   ll_q, ll_d;
    logic [16:0]   gen_q, gen_d;
    logic [7:0]    data_q, data_d, skid_data_q, skid_data_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    skid_type_q, skid_type_d;
    logic          skid_valid_q, skid_valid_d;
    logic          src_ready_q, src_ready_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          busy_q, busy_d, error_q, error_d;

    logic [16:0] p_len, nblk, tot_len, last_start;
    logic        pop, out_free, cur_src, prod, streaming, bad_job;
    logic [7:0]  gbyte, conf_byte;
    logic [1:0]  gtype;

    // bytes of the key block past kk are zero fill, not host data
    function automatic logic need_src(input logic [16:0] g,
                                      input logic [16:0] p,
                                      input logic [5:0]  k);
        logic fill;
        fill = (k != 6'd0) && (g < BLK) && (g >= {11'd0, k});
        return (g < p) && !fill;
    endfunction

    always_comb begin
        p_len      = {1'b0, ll_q} + ((kk_q != 6'd0) ? BLK : 17'd0);
        nblk       = (p_len == 17'd0) ? 17'd1 : (p_len + BLK - 17'd1) / BLK;
        tot_len    = nblk * BLK;
        last_start = tot_len - BLK;
    end

    always_comb begin
        case (gen_q)
            17'd0:   conf_byte = {2'b00, kk_q};
            17'd1:   conf_byte = {2'b00, nn_q};
            17'd2:   conf_byte = ll_q[7:0];
            17'd3:   conf_byte = ll_q[15:8];
            default: conf_byte = 8'h00;
        endcase
    end

    assign pop       = ctrl_q[0] & hash_ctrl_i[0];
    assign out_free  = !ctrl_q[0] || pop;
    assign streaming = (state_q == S_DATA) || (state_q == S_PAD);
    assign cur_src   = need_src(gen_q, p_len, kk_q);
    assign gbyte     = cur_src ? src_data_i : 8'h00;
    assign gtype     = (gen_q >= last_start) ? 2'b10 : 2'b01;
    assign bad_job   = (kk_q > 6'd32) || (nn_q == 6'd0) || (nn_q > 6'd32);
    assign prod      = streaming && (gen_q < tot_len) && !skid_valid_q &&
                       (!cur_src || (src_valid_i && src_ready_q));

    always_comb begin
        state_d      = state_q;
        kk_d         = kk_q;
        nn_d         = nn_q;
        ll_d         = ll_q;
        gen_d        = gen_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        skid_data_d  = skid_data_q;
        skid_type_d  = skid_type_q;
        skid_valid_d = skid_valid_q;
        tmo_d        = tmo_q;
        rcnt_d       = rcnt_q;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        res_last_d   = 1'b0;
        error_d      = error_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    kk_d    = key_len_i;
                    nn_d    = hash_len_i;
                    ll_d    = msg_len_i;
                    gen_d   = '0;
                    error_d = 1'b0;
                    state_d = S_CONF;
                end
            end
            S_CONF: begin
                if (bad_job) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (out_free) begin
                    if (gen_q < CFN) begin
                        data_d = conf_byte;
                        ctrl_d = 3'b001;
                        gen_d  = gen_q + 17'd1;
                    end else begin
                        ctrl_d  = 3'b000;
                        gen_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA, S_PAD: begin
                if (out_free) begin
                    if (skid_valid_q) begin
                        data_d       = skid_data_q;
                        ctrl_d       = {skid_type_q, 1'b1};
                        skid_valid_d = 1'b0;
                    end else if (prod) begin
                        data_d = gbyte;
                        ctrl_d = {gtype, 1'b1};
                    end else begin
                        ctrl_d = 3'b000;
                    end
                end else if (prod) begin
                    skid_data_d  = gbyte;
                    skid_type_d  = gtype;
                    skid_valid_d = 1'b1;
                end
                if (prod) gen_d = gen_q + 17'd1;
                if (gen_d == tot_len && !ctrl_d[0] && !skid_valid_d) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else if (state_q == S_DATA && gen_d >= p_len &&
                             p_len != tot_len) begin
                    state_d = S_PAD;
                end
            end
            S_WAIT, S_READ: begin
                if (hash_ctrl_i[1]) begin
                    res_valid_d = 1'b1;
                    res_data_d  = hash_i;
                    tmo_d       = '0;
                    if (state_q == S_WAIT) begin
                        res_last_d = (nn_q == 6'd1);
                        rcnt_d     = 6'd1;
                    end else begin
                        res_last_d = (rcnt_q == nn_q - 6'd1);
                        rcnt_d     = rcnt_q + 6'd1;
                    end
                    state_d = res_last_d ? S_IDLE : S_READ;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (hash_ctrl_i[1] && state_q != S_WAIT && state_q != S_READ)
            error_d = 1'b1;
        busy_d      = (state_d != S_IDLE);
        src_ready_d = ((state_d == S_DATA) || (state_d == S_PAD)) &&
                      !skid_valid_d && need_src(gen_d, p_len, kk_q);
    end

    always_ff @(posedge clk_io_bus or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            kk_q         <= '0;
            nn_q         <= '0;
            ll_q         <= '0;
            gen_q        <= '0;
            data_q       <= '0;
            ctrl_q       <= '0;
            skid_data_q  <= '0;
            skid_type_q  <= '0;
            skid_valid_q <= 1'b0;
            src_ready_q  <= 1'b0;
            tmo_q        <= '0;
            rcnt_q       <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kk_q         <= kk_d;
            nn_q         <= nn_d;
            ll_q         <= ll_d;
            gen_q        <= gen_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_type_q  <= skid_type_d;
            skid_valid_q <= skid_valid_d;
            src_ready_q  <= src_ready_d;
            tmo_q        <= tmo_d;
            rcnt_q       <= rcnt_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_last_q   <= res_last_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign src_ready_o = src_ready_q;
    assign data_o      = data_q;
    assign data_ctrl_o = ctrl_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_last_o  = res_last_q;
    assign busy_o      = busy_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_pmod_hash_sequencer.sv
// Bench for pmod_hash_sequencer: random jobs checked against a byte-stream
// model of the Pmod traffic built from kk/nn/ll.
module tb_pmod_hash_sequencer;

    localparam int CONF_N = 4;

    logic        clk_io_bus = 1'b0;
    logic        rst_async;
    logic        start_i;
    logic [5:0]  key_len_i;
    logic [5:0]  hash_len_i;
    logic [15:0] msg_len_i;
    logic        src_valid_i;
    logic [7:0]  src_data_i;
    logic        src_ready_o;
    logic [7:0]  data_o;
    logic [2:0]  data_ctrl_o;
    logic [7:0]  hash_i;
    logic [1:0]  hash_ctrl_i;
    logic        res_valid_o;
    logic [7:0]  res_data_o;
    logic        res_last_o;
    logic        busy_o;
    logic        error_o;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] cap[$];
    logic [9:0] expq[$];
    logic [8:0] resq[$];
    logic [7:0] srcq[$];
    logic [7:0] hq[$];
    int         src_idx;
    bit         abort;
    int         stab_err = 0;
    bit         hold = 1'b0;
    logic [7:0] hd;
    logic [2:0] hc;

    always #5 clk_io_bus = ~clk_io_bus;

    pmod_hash_sequencer dut (
        .clk_io_bus  (clk_io_bus),
        .rst_async   (rst_async),
        .start_i     (start_i),
        .key_len_i   (key_len_i),
        .hash_len_i  (hash_len_i),
        .msg_len_i   (msg_len_i),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .data_o      (data_o),
        .data_ctrl_o (data_ctrl_o),
        .hash_i      (hash_i),
        .hash_ctrl_i (hash_ctrl_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_last_o  (res_last_o),
        .busy_o      (busy_o),
        .error_o     (error_o)
    );

    always @(negedge clk_io_bus) begin
        if (rst_async) begin
            hold = 1'b0;
        end else begin
            if (hold && (data_o !== hd || data_ctrl_o !== hc)) stab_err++;
            hold = data_ctrl_o[0] && !hash_ctrl_i[0];
            hd   = data_o;
            hc   = data_ctrl_o;
            if (data_ctrl_o[0] && hash_ctrl_i[0])
                cap.push_back({data_ctrl_o[2:1], data_o});
            if (res_valid_o) resq.push_back({res_last_o, res_data_o});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_io_bus);
        #1;
    endtask

    // mode 0: full job, 1: no hash returned, 2: reset at data byte 20
    task automatic run_job(input int kk, input int nn, input int ll,
                           input bit bp, input int mode);
        logic [7:0] pay[$];
        int tot;
        int c1, c2, c3;
        srcq.delete(); expq.delete(); hq.delete();
        cap.delete(); resq.delete();
        abort = 1'b0;
        src_idx = 0;
        c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < kk + ll; i++) srcq.push_back(8'($urandom));
        for (int i = 0; i < kk; i++) pay.push_back(srcq[i]);
        if (kk > 0) while (pay.size() < 64) pay.push_back(8'h00);
        for (int i = 0; i < ll; i++) pay.push_back(srcq[kk + i]);
        tot = (pay.size() == 0) ? 64 : ((pay.size() + 63) / 64) * 64;
        while (pay.size() < tot) pay.push_back(8'h00);
        expq.push_back({2'b00, 8'(kk)});
        expq.push_back({2'b00, 8'(nn)});
        expq.push_back({2'b00, 8'(ll & 255)});
        expq.push_back({2'b00, 8'(ll >> 8)});
        for (int i = 0; i < tot; i++)
            expq.push_back({(i >= tot - 64) ? 2'b10 : 2'b01, pay[i]});
        for (int i = 0; i < nn; i++) hq.push_back(8'($urandom));

        key_len_i  = 6'(kk);
        hash_len_i = 6'(nn);
        msg_len_i  = 16'(ll);
        start_i    = 1'b1;
        step(1);
        start_i = 1'b0;
        chk("err_clr", error_o, 0);
        chk("busy_set", busy_o, 1);

        fork
            begin
                while (src_idx < srcq.size() && !abort && c1 < 5000) begin
                    src_valid_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                    src_data_i  = srcq[src_idx];
                    @(negedge clk_io_bus);
                    if (src_valid_i && src_ready_o) src_idx++;
                    step(1);
                    c1++;
                end
                src_valid_i = 1'b0;
            end
            begin
                while (cap.size() < expq.size() && !abort && c2 < 5000) begin
                    hash_ctrl_i[0] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    step(1);
                    c2++;
                end
                hash_ctrl_i[0] = 1'b1;
                if (mode == 0 && !abort) begin
                    for (int j = 0; j < nn; j++) begin
                        step($urandom_range(0, 3));
                        hash_ctrl_i[1] = 1'b1;
                        hash_i = hq[j];
                        step(1);
                        hash_ctrl_i[1] = 1'b0;
                    end
                end
            end
            begin
                if (mode == 2) begin
                    while (cap.size() < CONF_N + 20 && c3 < 5000) begin
                        step(1);
                        c3++;
                    end
                    rst_async = 1'b1;
                    #1;
                    chk("rst_data", data_o, 0);
                    chk("rst_ctrl", data_ctrl_o, 0);
                    chk("rst_ready", src_ready_o, 0);
                    chk("rst_busy", busy_o, 0);
                    chk("rst_res", {res_valid_o, res_last_o, res_data_o}, 0);
                    abort = 1'b1;
                    step(3);
                    rst_async = 1'b0;
                    step(4);
                end
            end
        join
        step(3);

        if (mode == 2) chk("rst_count", cap.size(), CONF_N + 20);
        else           chk("xfer_count", cap.size(), expq.size());
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            chk("xfer_byte", cap[i], expq[i]);
            if (cap[i] !== expq[i]) break;
        end
        if (mode == 0) begin
            chk("res_count", resq.size(), nn);
            for (int i = 0; i < resq.size() && i < nn; i++) begin
                chk("res_byte", resq[i], {1'(i == nn - 1), hq[i]});
                if (resq[i] !== {1'(i == nn - 1), hq[i]}) break;
            end
            chk("done_busy", busy_o, 0);
            chk("done_err", error_o, 0);
        end
        if (mode == 1) begin
            step(4085);
            chk("tmo_early_err", error_o, 0);
            chk("tmo_early_busy", busy_o, 1);
            step(12);
            chk("tmo_err", error_o, 1);
            chk("tmo_busy", busy_o, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_async   = 1'b1;
        start_i     = 1'b0;
        key_len_i   = '0;
        hash_len_i  = '0;
        msg_len_i   = '0;
        src_valid_i = 1'b0;
        src_data_i  = '0;
        hash_i      = '0;
        hash_ctrl_i = 2'b00;
        #22;
        chk("reset_data", data_o, 0);
        chk("reset_ctrl", data_ctrl_o, 0);
        chk("reset_ready", src_ready_o, 0);
        chk("reset_res", {res_valid_o, res_last_o, res_data_o}, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_err", error_o, 0);
        step(1);
        rst_async = 1'b0;
        step(4);

        run_job(0, 32, 3, 1'b0, 0);
        run_job(16, 32, 64, 1'b0, 0);
        run_job(0, 32, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            run_job($urandom_range(0, 32), $urandom_range(1, 32),
                    $urandom_range(0, 200), 1'b1, 0);
        run_job(32, 1, 0, 1'b1, 0);
        run_job(0, 16, 128, 1'b1, 0);
        run_job(1, 32, 65, 1'b1, 0);

        run_job(7, 20, 10, 1'b0, 1);
        run_job(0, 8, 5, 1'b1, 0);

        cap.delete();
        hash_ctrl_i[0] = 1'b1;
        key_len_i  = 6'd33;
        hash_len_i = 6'd16;
        msg_len_i  = 16'd4;
        start_i    = 1'b1;
        step(1);
        start_i = 1'b0;
        step(3);
        chk("badkk_err", error_o, 1);
        chk("badkk_busy", busy_o, 0);
        chk("badkk_bytes", cap.size(), 0);

        key_len_i  = 6'd0;
        hash_len_i = 6'd0;
        start_i    = 1'b1;
        step(1);
        start_i = 1'b0;
        step(3);
        chk("badnn_err", error_o, 1);
        chk("badnn_bytes", cap.size(), 0);

        run_job(3, 4, 9, 1'b0, 0);

        resq.delete();
        hash_ctrl_i[1] = 1'b1;
        hash_i = 8'hA5;
        step(1);
        hash_ctrl_i[1] = 1'b0;
        chk("idle_hash_err", error_o, 1);
        step(2);
        chk("idle_hash_res", resq.size(), 0);

        run_job(0, 32, 100, 1'b0, 2);
        run_job(5, 20, 70, 1'b1, 0);

        chk("stable_hold", stab_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
